muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
// - Multi-cycle multiply/divide controller for the EX stage, next to alucontrol and the ALU.
// - Accepts MUL/DIV requests from decode and iterates shift-add / restoring-divide over WIDTH cycles.
// - Stalls the pipeline while it runs and returns a HI/LO result pair.
// - Single-cycle ops stay on the existing ALU path; this block only sequences the long ops.
// PARAMETERS
// - WIDTH    16  operand width in bits; also the iteration count
// - CNT_W     5  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clk           in   1        rising-edge clock; the only clock
// - rst           in   1        synchronous reset, active-high
// - start         in   1        request strobe; sampled in IDLE only
// - functionCode  in   4        4'b1100 = MUL, 4'b1101 = DIV; any other code is ignored
// - opA           in   WIDTH    multiplicand / dividend; captured when start is accepted
// - opB           in   WIDTH    multiplier / divisor; captured when start is accepted
// - flush         in   1        aborts an in-flight op (branch mispredict / exception)
// - stall         out  1        pipeline hold request
// - busy          out  1        high when state is MUL or DIV
// - done          out  1        one-cycle pulse; result valid
// - resultHi      out  WIDTH    MUL: product[2W-1:W]; DIV: remainder
// - resultLo      out  WIDTH    MUL: product[W-1:0]; DIV: quotient
// - divByZero     out  1        sticky flag for the last DIV; cleared by the next accepted start
// BEHAVIOUR
// - Reset: state=IDLE; stall, busy, done, divByZero = 0; resultHi, resultLo = 0; counter = 0.
//   Reset wins over every other input, including mid-operation.
// - Accept condition: state==IDLE && start && functionCode in {MUL, DIV}.
//   On accept: latch opA and opB, clear counter and divByZero, go to MUL or DIV.
// - stall (combinational) = accept | busy. stall is 0 in DONE, so the pipeline advances
//   in the same cycle done is high.
// - MUL state: unsigned shift-add. Each cycle, if multiplier LSB = 1, add multiplicand
//   into the upper accumulator (WIDTH+1 bits, keeping the carry); then shift right 1.
//   After WIDTH iterations go to DONE.
// - DIV state: unsigned restoring division. Each cycle, shift {rem, quo} left 1 and
//   trial-subtract the divisor (WIDTH+1-bit compare). If no borrow, keep the difference
//   and set quo LSB = 1. After WIDTH iterations go to DONE.
// - Divide by zero (opB==0 at accept): go straight DIV->DONE after 1 cycle.
//   resultLo = all ones, resultHi = opA, divByZero = 1.
// - Latency: accept at cycle N; done=1 at cycle N+WIDTH+1 (N+2 for divide by zero).
// - DONE: done=1 for exactly one cycle; resultHi and resultLo update here, then return
//   to IDLE. A start seen in DONE is ignored; the requester re-presents it in IDLE.
// - Results hold their last value until the next DONE. They are never cleared by flush.
// - start while busy: ignored; no re-latch.
// - flush: in MUL/DIV, next state = IDLE with no done pulse and results unchanged.
//   In DONE, the done pulse still occurs. flush and start in the same IDLE cycle: flush wins,
//   nothing is accepted.
// - Counter reaching WIDTH-1 marks the last iteration; no wrap is possible before the
//   state exits.
// CONFIGURATION
// - Macro MULDIV_SIGNED_EN.
// - Defined: functionCodes 4'b1110 = MULS and 4'b1111 = DIVS are also accepted.
//   Operands are converted to magnitudes at accept. Sign fix-up is applied in DONE:
//   product negated if signs differ; quotient sign = signA ^ signB; remainder sign = signA.
//   This adds no extra cycle.
// - Undefined: 4'b1110 and 4'b1111 are ignored like any other non-MUL/DIV code; the logic
//   is unsigned only.
// STRUCTURE
// - Package muldiv_pkg: FC_MUL, FC_DIV, FC_MULS, FC_DIVS constants; state typedef
//   {IDLE, MUL, DIV, DONE} (2-bit encoding).
// - One sub-module, muldiv_datapath: holds the accumulator/remainder, quotient and
//   operand registers, the adder/subtractor and the shifter, under step/load/mode controls.
// - This module keeps only the FSM, the counter and the handshake logic.
// TESTING (WIDTH=16)
// - MUL 3*5, start at cycle 0 -> stall high for cycles 0-16; done at cycle 17;
//   resultHi=0x0000, resultLo=0x000F.
// - MUL 0xFFFF*0xFFFF -> resultHi=0xFFFE, resultLo=0x0001; busy low after done.
// - DIV 100/7 -> resultLo=14, resultHi=2, divByZero=0; start during busy changes nothing.
// - DIV 5/0 -> done at cycle 2; resultLo=0xFFFF, resultHi=5, divByZero=1.
// - MUL started, flush at cycle 6 -> IDLE at cycle 7; no done; results keep their prior values.
// - rst at cycle 8 of a DIV -> all outputs 0 on the next edge; functionCode=4'b0010 with
//   start -> not accepted, stall=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - function codes recognised on the decode interface
//   - FSM state encoding (2 bits)
//   - datapath operating mode
// Optional feature macro: MULDIV_SIGNED_EN (adds MULS/DIVS, see muldiv_sequencer).
// ----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [3:0] FC_MUL  = 4'b1100;
    localparam logic [3:0] FC_DIV  = 4'b1101;
    localparam logic [3:0] FC_MULS = 4'b1110;
    localparam logic [3:0] FC_DIVS = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage

// File: rtl/muldiv_if.sv
// ----------------------------------------------------------------------------
// muldiv_if
// Request/result bundle between decode/EX pipeline control and the
// multiply/divide sequencer.
//   master (pipeline side) drives : start, functionCode, opA, opB, flush
//   slave  (sequencer side) drives: stall, busy, done, resultHi, resultLo,
//                                   divByZero
// Parameter WIDTH: operand/result width in bits.
// ----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       functionCode;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultHi;
    logic [WIDTH-1:0] resultLo;
    logic             divByZero;

    modport master (
        output start, functionCode, opA, opB, flush,
        input  stall, busy, done, resultHi, resultLo, divByZero
    );

    modport slave (
        input  start, functionCode, opA, opB, flush,
        output stall, busy, done, resultHi, resultLo, divByZero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// ----------------------------------------------------------------------------
// muldiv_datapath
// Operand and working registers for the iterative multiply / divide:
//   acc_q : upper accumulator (MUL, WIDTH+1 bits keeps the carry) or
//           partial remainder (DIV)
//   lo_q  : multiplier shifting into product low half (MUL) or
//           dividend shifting into quotient (DIV)
//   opd_q : multiplicand (MUL) or divisor (DIV)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load_i        capture operands (magnitudes) and mode, clear accumulator
//   step_i        perform one shift-add / restoring-divide iteration
//   mode_i        MODE_MUL or MODE_DIV for the captured operation
//   signed_i      (MULDIV_SIGNED_EN only) operands are two's complement
//   op_a_i/op_b_i raw operands from the request
//   div_zero_o    captured divisor is zero
//   res_hi_o/lo_o final result as it will look after the current cycle,
//                 including sign fix-up; the sequencer registers it
// Macro MULDIV_SIGNED_EN adds magnitude conversion and sign fix-up.
// ----------------------------------------------------------------------------
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  mode_t            mode_i,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_i,
`endif
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opd_q;
    mode_t              mode_q;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic               sign_a_s, sign_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [WIDTH-1:0]   fin_hi_s, fin_lo_s;
    logic [2*WIDTH-1:0] prod_s;

`ifdef MULDIV_SIGNED_EN
    logic sign_a_q, sign_b_q;

    // Operand signs, remembered for the fix-up when the result is produced
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (load_i) begin
            sign_a_q <= signed_i & op_a_i[WIDTH-1];
            sign_b_q <= signed_i & op_b_i[WIDTH-1];
        end
    end

    // Iterate on magnitudes; the most negative value maps to itself, which
    // still reads correctly as an unsigned magnitude
    assign mag_a_s  = (signed_i && op_a_i[WIDTH-1]) ? ({WIDTH{1'b0}} - op_a_i) : op_a_i;
    assign mag_b_s  = (signed_i && op_b_i[WIDTH-1]) ? ({WIDTH{1'b0}} - op_b_i) : op_b_i;
    assign sign_a_s = sign_a_q;
    assign sign_b_s = sign_b_q;
`else
    assign mag_a_s  = op_a_i;
    assign mag_b_s  = op_b_i;
    assign sign_a_s = 1'b0;
    assign sign_b_s = 1'b0;
`endif

    assign div_zero_o = (opd_q == {WIDTH{1'b0}});

    // One iteration of shift-add (MUL) or restoring division (DIV)
    always_comb begin
        acc_d       = acc_q;
        lo_d        = lo_q;
        mul_sum_s   = acc_q + {1'b0, (lo_q[0] ? opd_q : {WIDTH{1'b0}})};
        div_shift_s = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opd_q};
        if (mode_q == MODE_MUL) begin
            acc_d = {1'b0, mul_sum_s[WIDTH:1]};
            lo_d  = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff_s[WIDTH+1]) begin
            acc_d = div_diff_s[WIDTH:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = div_shift_s;
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Result as it stands after this cycle (includes the final step if one
    // happens now), with sign fix-up so no extra cycle is needed
    always_comb begin
        fin_hi_s = step_i ? acc_d[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fin_lo_s = step_i ? lo_d : lo_q;
        prod_s   = {fin_hi_s, fin_lo_s};
        res_hi_o = fin_hi_s;
        res_lo_o = fin_lo_s;
        if (mode_q == MODE_MUL) begin
            if (sign_a_s ^ sign_b_s) begin
                prod_s = {(2*WIDTH){1'b0}} - prod_s;
            end else begin
                prod_s = {fin_hi_s, fin_lo_s};
            end
            res_hi_o = prod_s[2*WIDTH-1:WIDTH];
            res_lo_o = prod_s[WIDTH-1:0];
        end else if (div_zero_o) begin
            // Divisor zero: no iteration ran, lo_q still holds |opA|
            res_lo_o = {WIDTH{1'b1}};
            res_hi_o = sign_a_s ? ({WIDTH{1'b0}} - fin_lo_s) : fin_lo_s;
        end else begin
            res_lo_o = (sign_a_s ^ sign_b_s) ? ({WIDTH{1'b0}} - fin_lo_s) : fin_lo_s;
            res_hi_o = sign_a_s ? ({WIDTH{1'b0}} - fin_hi_s) : fin_hi_s;
        end
    end

    // Working registers: load on accept, update on each iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= {(WIDTH+1){1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            opd_q  <= {WIDTH{1'b0}};
            mode_q <= MODE_MUL;
        end else if (load_i) begin
            acc_q  <= {(WIDTH+1){1'b0}};
            lo_q   <= mag_a_s;
            opd_q  <= mag_b_s;
            mode_q <= mode_i;
        end else if (step_i) begin
            acc_q  <= acc_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle multiply/divide controller for the EX stage. Accepts MUL/DIV
// requests in IDLE, iterates WIDTH cycles in the datapath, stalls the
// pipeline meanwhile and returns a registered HI/LO pair with a one-cycle
// done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high, overrides everything
//   bus  muldiv_if.slave: start/functionCode/opA/opB/flush in,
//        stall/busy/done/resultHi/resultLo/divByZero out
// Parameters: WIDTH operand width and iteration count; CNT_W counter width
//             (2**CNT_W > WIDTH).
// Macro MULDIV_SIGNED_EN: also accept MULS (4'b1110) and DIVS (4'b1111).
// ----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div0_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;
    logic             is_mul_s, is_div_s, is_signed_s;
    logic             accept_s, busy_s, last_s, step_s, finish_s, div_zero_s;
    logic [WIDTH-1:0] dp_hi_s, dp_lo_s;

    // Function-code decode; unknown codes leave both flags low
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        case (bus.functionCode)
            FC_MUL:  is_mul_s = 1'b1;
            FC_DIV:  is_div_s = 1'b1;
`ifdef MULDIV_SIGNED_EN
            FC_MULS: begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
            FC_DIVS: begin is_div_s = 1'b1; is_signed_s = 1'b1; end
`endif
            default: begin is_mul_s = 1'b0; is_div_s = 1'b0; end
        endcase
    end

    // flush beats start in IDLE; reset beats both
    assign accept_s = !rst && !bus.flush && (state_q == IDLE) && bus.start
                      && (is_mul_s || is_div_s);
    assign busy_s   = (state_q == MUL) || (state_q == DIV);
    assign last_s   = (cnt_q == CNT_W'(WIDTH - 1));
    assign finish_s = (state_d == DONE) && (state_q != DONE);

    // Next-state, iteration counter and step strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = is_mul_s ? MUL : DIV;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    step_s  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_s ? DONE : MUL;
                end
            end
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (div_zero_s) begin
                    state_d = DONE;
                end else begin
                    step_s  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_s ? DONE : DIV;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers and sticky divide-by-zero flag; results only move
    // when an operation completes, never on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            res_hi_q <= {WIDTH{1'b0}};
            res_lo_q <= {WIDTH{1'b0}};
            div0_q   <= 1'b0;
        end else if (finish_s) begin
            res_hi_q <= dp_hi_s;
            res_lo_q <= dp_lo_s;
            div0_q   <= (state_q == DIV) && div_zero_s;
        end else if (accept_s) begin
            div0_q   <= 1'b0;
        end
    end

    muldiv_datapath #(
        .WIDTH      (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s),
        .step_i     (step_s),
        .mode_i     (is_div_s ? MODE_DIV : MODE_MUL),
`ifdef MULDIV_SIGNED_EN
        .signed_i   (is_signed_s),
`endif
        .op_a_i     (bus.opA),
        .op_b_i     (bus.opB),
        .div_zero_o (div_zero_s),
        .res_hi_o   (dp_hi_s),
        .res_lo_o   (dp_lo_s)
    );

`ifndef MULDIV_SIGNED_EN
    // Signed requests do not exist in this build
    logic unused_signed_s;
    assign unused_signed_s = is_signed_s;
`endif

    assign bus.stall     = accept_s | busy_s;
    assign bus.busy      = busy_s;
    assign bus.done      = (state_q == DONE);
    assign bus.resultHi  = res_hi_q;
    assign bus.resultLo  = res_lo_q;
    assign bus.divByZero = div0_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer (WIDTH=16). Expected results come
// from plain integer arithmetic on the request operands.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] exp_hi, exp_lo;

    muldiv_if #(.WIDTH(16)) bus();

    muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: result of an operation computed from its arithmetic meaning
    function automatic void model(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] hi, output logic [15:0] lo,
                                  output logic dz, output int lat);
        logic [31:0] p;
        int sa, sb, q, r;
        hi = 16'h0; lo = 16'h0; dz = 1'b0; lat = 17;
        sa = $signed(a); sb = $signed(b);
        case (fc)
            4'b1100: begin p = 32'(a) * 32'(b); hi = p[31:16]; lo = p[15:0]; end
            4'b1101: begin
                if (b == 16'h0) begin lo = 16'hFFFF; hi = a; dz = 1'b1; lat = 2; end
                else begin lo = a / b; hi = a % b; end
            end
            4'b1110: begin q = sa * sb; hi = q[31:16]; lo = q[15:0]; end
            4'b1111: begin
                if (b == 16'h0) begin lo = 16'hFFFF; hi = a; dz = 1'b1; lat = 2; end
                else begin q = sa / sb; r = sa % sb; lo = q[15:0]; hi = r[15:0]; end
            end
            default: ;
        endcase
    endfunction

    function automatic bit accepted(input logic [3:0] fc);
`ifdef MULDIV_SIGNED_EN
        return fc >= 4'b1100;
`else
        return (fc == 4'b1100) || (fc == 4'b1101);
`endif
    endfunction

    // Present one request and wait (bounded) for done
    task automatic run_op(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic stall_ok, output logic done_stall);
        @(negedge clk);
        bus.start = 1'b1; bus.functionCode = fc; bus.opA = a; bus.opB = b;
        #1 stall_ok = (bus.stall === 1'b1);
        lat = 0; done_stall = 1'bx;
        while (lat < 60) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.done === 1'b1) begin done_stall = bus.stall; break; end
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
        bus.functionCode = 4'h0; bus.opA = 16'h0; bus.opB = 16'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.stall, bus.divByZero, bus.resultHi, bus.resultLo} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {bus.busy, bus.done, bus.stall, bus.divByZero, bus.resultHi, bus.resultLo});
        end
        rst = 1'b0; exp_hi = 16'h0; exp_lo = 16'h0;
    endtask

    task automatic test_mul();
        logic [15:0] mh, ml; logic mdz; int mlat, lat; logic sok, dst;
        logic [15:0] av [2] = '{16'd3, 16'hFFFF};
        logic [15:0] bv [2] = '{16'd5, 16'hFFFF};
        for (int i = 0; i < 2; i++) begin
            run_op(4'b1100, av[i], bv[i], lat, sok, dst);
            model(4'b1100, av[i], bv[i], mh, ml, mdz, mlat);
            checks++;
            if (lat !== mlat) begin failures++; $display("FAIL mul_latency got=%0d required=%0d", lat, mlat); end
            checks++;
            if (sok !== 1'b1 || dst !== 1'b0) begin failures++; $display("FAIL mul_stall got=%b/%b required=1/0", sok, dst); end
            checks++;
            if ({bus.resultHi, bus.resultLo} !== {mh, ml}) begin
                failures++; $display("FAIL mul_result got=%h_%h required=%h_%h", bus.resultHi, bus.resultLo, mh, ml);
            end
            exp_hi = mh; exp_lo = ml;
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mul_after_done got=%b%b required=00", bus.busy, bus.done); end
    endtask

    task automatic test_div();
        logic [15:0] mh, ml; logic mdz; int mlat, lat; logic sok, dst;
        // 100/7 with a competing start during busy
        @(negedge clk);
        bus.start = 1'b1; bus.functionCode = 4'b1101; bus.opA = 16'd100; bus.opB = 16'd7;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            bus.start = (lat >= 3 && lat <= 5);
            if (lat == 3) begin bus.functionCode = 4'b1100; bus.opA = 16'd9; bus.opB = 16'd9; end
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        model(4'b1101, 16'd100, 16'd7, mh, ml, mdz, mlat);
        checks++;
        if (lat !== mlat) begin failures++; $display("FAIL div_latency got=%0d required=%0d", lat, mlat); end
        checks++;
        if ({bus.resultHi, bus.resultLo, bus.divByZero} !== {mh, ml, mdz}) begin
            failures++; $display("FAIL div_result got=%h_%h_%b required=%h_%h_%b", bus.resultHi, bus.resultLo, bus.divByZero, mh, ml, mdz);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL div_busy_start_ignored got=%b required=0", bus.busy); end
        // divide by zero
        run_op(4'b1101, 16'd5, 16'd0, lat, sok, dst);
        model(4'b1101, 16'd5, 16'd0, mh, ml, mdz, mlat);
        checks++;
        if (lat !== mlat) begin failures++; $display("FAIL div0_latency got=%0d required=%0d", lat, mlat); end
        checks++;
        if ({bus.resultHi, bus.resultLo, bus.divByZero} !== {mh, ml, mdz}) begin
            failures++; $display("FAIL div0_result got=%h_%h_%b required=%h_%h_%b", bus.resultHi, bus.resultLo, bus.divByZero, mh, ml, mdz);
        end
        // next accepted start clears the sticky flag
        @(negedge clk);
        bus.start = 1'b1; bus.functionCode = 4'b1100; bus.opA = 16'd2; bus.opB = 16'd2;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.divByZero !== 1'b0) begin failures++; $display("FAIL div0_clear got=%b required=0", bus.divByZero); end
        lat = 1;
        while (lat < 60 && bus.done !== 1'b1) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 17 || {bus.resultHi, bus.resultLo} !== 32'd4) begin
            failures++; $display("FAIL mul_after_div0 got=%0d/%h required=17/4", lat, {bus.resultHi, bus.resultLo});
        end
        exp_hi = 16'h0; exp_lo = 16'd4;
    endtask

    task automatic test_flush();
        bit seen_done;
        @(negedge clk);
        bus.start = 1'b1; bus.functionCode = 4'b1100; bus.opA = 16'd1234; bus.opB = 16'd77;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 6) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b%b required=00", bus.busy, bus.stall); end
        seen_done = 1'b0;
        repeat (25) begin @(negedge clk); if (bus.done === 1'b1) seen_done = 1'b1; end
        checks++;
        if (seen_done !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b required=0", seen_done); end
        checks++;
        if ({bus.resultHi, bus.resultLo} !== {exp_hi, exp_lo}) begin
            failures++; $display("FAIL flush_results got=%h_%h required=%h_%h", bus.resultHi, bus.resultLo, exp_hi, exp_lo);
        end
        // flush and start together in IDLE: nothing accepted
        bus.start = 1'b1; bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_start_stall got=%b required=0", bus.stall); end
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b required=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.functionCode = 4'b1101; bus.opA = 16'd1000; bus.opB = 16'd3;
        for (int c = 1; c <= 8; c++) begin @(negedge clk); bus.start = 1'b0; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.stall, bus.divByZero, bus.resultHi, bus.resultLo} !== 36'h0) begin
            failures++; $display("FAIL reset_mid got=%h required=0", {bus.busy, bus.done, bus.stall, bus.divByZero, bus.resultHi, bus.resultLo});
        end
        rst = 1'b0; exp_hi = 16'h0; exp_lo = 16'h0;
        bus.start = 1'b1; bus.functionCode = 4'b0010;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL bad_code_stall got=%b required=0", bus.stall); end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL bad_code_busy got=%b required=0", bus.busy); end
    endtask

    task automatic test_ignored_codes();
        for (int c = 0; c < 16; c++) begin
            if (!accepted(4'(c))) begin
                @(negedge clk);
                bus.start = 1'b1; bus.functionCode = 4'(c); bus.opA = 16'd7; bus.opB = 16'd3;
                #1;
                checks++;
                if (bus.stall !== 1'b0) begin failures++; $display("FAIL ignored_code_%0d stall=%b required=0", c, bus.stall); end
                @(negedge clk);
                bus.start = 1'b0;
                checks++;
                if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignored_code_%0d busy=%b required=0", c, bus.busy); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mh, ml; logic mdz; int mlat, lat;
        @(negedge clk);
        bus.start = 1'b1; bus.functionCode = 4'b1100; bus.opA = 16'd200; bus.opB = 16'd300;
        lat = 0;
        while (lat < 60) begin @(negedge clk); lat++; if (bus.done === 1'b1) break; end
        model(4'b1100, 16'd200, 16'd300, mh, ml, mdz, mlat);
        checks++;
        if (lat !== 17 || bus.stall !== 1'b0 || {bus.resultHi, bus.resultLo} !== {mh, ml}) begin
            failures++; $display("FAIL b2b_first got=%0d/%b/%h required=17/0/%h", lat, bus.stall, {bus.resultHi, bus.resultLo}, {mh, ml});
        end
        // start still high in DONE with new operands: only the IDLE cycle may take it
        bus.opA = 16'd4321; bus.opB = 16'd55;
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b%b required=10", bus.stall, bus.busy); end
        lat = 0;
        while (lat < 60) begin @(negedge clk); bus.start = 1'b0; lat++; if (bus.done === 1'b1) break; end
        model(4'b1100, 16'd4321, 16'd55, mh, ml, mdz, mlat);
        checks++;
        if (lat !== 17 || {bus.resultHi, bus.resultLo} !== {mh, ml}) begin
            failures++; $display("FAIL b2b_second got=%0d/%h required=17/%h", lat, {bus.resultHi, bus.resultLo}, {mh, ml});
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, mh, ml; logic [3:0] fc; logic mdz; int mlat, lat; logic sok, dst;
        for (int n = 0; n < 40; n++) begin
`ifdef MULDIV_SIGNED_EN
            fc = 4'b1100 + 4'($urandom_range(0, 3));
`else
            fc = 4'b1100 + 4'($urandom_range(0, 1));
`endif
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if (n == 0) begin a = 16'h8000; b = 16'hFFFF; end
            run_op(fc, a, b, lat, sok, dst);
            model(fc, a, b, mh, ml, mdz, mlat);
            checks++;
            if (lat !== mlat || sok !== 1'b1 || dst !== 1'b0) begin
                failures++; $display("FAIL rand_timing fc=%b a=%h b=%h got=%0d/%b/%b required=%0d/1/0", fc, a, b, lat, sok, dst, mlat);
            end
            checks++;
            if ({bus.resultHi, bus.resultLo, bus.divByZero} !== {mh, ml, mdz}) begin
                failures++; $display("FAIL rand_result fc=%b a=%h b=%h got=%h_%h_%b required=%h_%h_%b",
                                     fc, a, b, bus.resultHi, bus.resultLo, bus.divByZero, mh, ml, mdz);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_ignored_codes();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
